// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: round-robin arbiter giving NCORES cores access to one
// shared single-port memory of 2**AW 32-bit words. Each access takes one
// IDLE -> GRANT -> DONE pass: grant one cycle after the request, ack/rdata
// one cycle after that.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req_valid  per-core request            req_wr    per-core direction (1=write)
//   req_addr   per-core byte address       req_wdata per-core write data
//              (core i in bits [32*i+31:32*i])
//   grant      one-hot registered grant    ack       one-hot one-cycle completion
//   rdata      read data, valid with ack   busy      state is not IDLE
//   err        out-of-range strobe with ack (bounds-check builds only)
//
// Optional feature: define SHMEM_BOUNDS_CHECK_EN to enable address bounds
// checking. Default build ignores address bits above AW+1 (wraps modulo depth).
module shared_mem_arbiter #(
  parameter int unsigned NCORES = 4,
  parameter int unsigned AW     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NCORES-1:0]        req_valid,
  input  logic [NCORES-1:0]        req_wr,
  input  logic [32*NCORES-1:0]     req_addr,
  input  logic [32*NCORES-1:0]     req_wdata,
  output logic [NCORES-1:0]        grant,
  output logic [NCORES-1:0]        ack,
  output logic [31:0]              rdata,
  output logic                     busy,
  output logic                     err
);

  localparam int unsigned PW    = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int unsigned SW    = PW + 1;
  localparam int unsigned DEPTH = 32'(1) << AW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;

  logic [31:0]       r_mem [DEPTH];

  logic [NCORES-1:0] r_grant;
  logic [NCORES-1:0] r_ack;
  logic [31:0]       r_rdata;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_winner;
  logic              r_wr;
  logic [31:0]       r_wdata;
  logic [AW-1:0]     r_word;

  logic              w_any;
  logic [PW-1:0]     w_winner;
  logic [PW-1:0]     w_next_ptr;
  logic              w_sel_wr;
  logic [31:0]       w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic              w_oob;
  logic              w_busy;
  logic              w_mem_we;
  logic              w_rd_en;

  // Bounds checking: latch whether the upper address bits were nonzero.
`ifdef SHMEM_BOUNDS_CHECK_EN
  logic              r_oob;
  logic              r_err;
  logic              w_unused_addr;
  assign w_oob         = r_oob;
  assign err           = r_err;
  assign w_unused_addr = ^w_sel_addr[1:0];
`else
  logic              w_unused_addr;
  assign w_oob         = 1'b0;
  assign err           = 1'b0;
  assign w_unused_addr = ^{w_sel_addr[31:AW+2], w_sel_addr[1:0]};
`endif

  assign grant = r_grant;
  assign ack   = r_ack;
  assign rdata = r_rdata;
  assign busy  = w_busy;

  // Round-robin pick: first requesting core at or after r_rr_ptr, wrapping.
  always_comb begin
    logic          found;
    logic [SW-1:0] sum;
    logic [PW-1:0] idx;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    w_winner = r_rr_ptr;
    for (int k = 0; k < NCORES; k++) begin
      sum = {1'b0, r_rr_ptr} + SW'(k);
      idx = (sum >= SW'(NCORES)) ? PW'(sum - SW'(NCORES)) : PW'(sum);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        w_winner = idx;
      end
    end
  end

  assign w_any = |req_valid;

  // Mux the winning core's request fields.
  always_comb begin
    w_sel_wr    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NCORES; i++) begin
      if (PW'(i) == w_winner) begin
        w_sel_wr    = req_wr[i];
        w_sel_addr  = req_addr[32*i +: 32];
        w_sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  assign w_next_ptr = (r_winner == PW'(NCORES - 1)) ? '0 : r_winner + PW'(1);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next_state = S_GRANT;
      S_GRANT: w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State-decoded controls; the access itself happens on the GRANT edge.
  always_comb begin
    w_busy   = 1'b0;
    w_mem_we = 1'b0;
    w_rd_en  = 1'b0;
    case (r_state)
      S_GRANT: begin
        w_busy   = 1'b1;
        w_mem_we = r_wr && !w_oob;
        w_rd_en  = !r_wr;
      end
      S_DONE:  w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
  end

  // Request latch, grant/ack strobes, read data and round-robin pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant  <= '0;
      r_ack    <= '0;
      r_rdata  <= '0;
      r_rr_ptr <= '0;
      r_winner <= '0;
      r_wr     <= 1'b0;
      r_wdata  <= '0;
      r_word   <= '0;
`ifdef SHMEM_BOUNDS_CHECK_EN
      r_oob    <= 1'b0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
`ifdef SHMEM_BOUNDS_CHECK_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_winner <= w_winner;
            r_wr     <= w_sel_wr;
            r_wdata  <= w_sel_wdata;
            r_word   <= w_sel_addr[AW+1:2];
`ifdef SHMEM_BOUNDS_CHECK_EN
            r_oob    <= |w_sel_addr[31:AW+2];
`endif
            r_grant  <= NCORES'(1) << w_winner;
          end
        end
        S_GRANT: begin
          r_grant <= '0;
          r_ack   <= NCORES'(1) << r_winner;
          if (w_rd_en) r_rdata <= w_oob ? '0 : r_mem[r_word];
`ifdef SHMEM_BOUNDS_CHECK_EN
          r_err   <= r_oob;
`endif
        end
        S_DONE:  r_rr_ptr <= w_next_ptr;
        default: r_grant  <= '0;
      endcase
    end
  end

  // Shared memory; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_word] <= r_wdata;
  end

endmodule

// File: doc/shared_mem_arbiter.md
SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

Interface
REQ-001 SHALL have parameter NCORES, default 4, number of requesting cores (2..16).
REQ-002 SHALL have parameter AW, default 8, word-address width; shared memory depth is 2**AW 32-bit words.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NCORES  per-core access request; bit i for core i.
REQ-006 SHALL have port req_wr  input  NCORES  per-core direction; 1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  32*NCORES  per-core byte address; core i in bits [32*i+31:32*i].
REQ-008 SHALL have port req_wdata  input  32*NCORES  per-core write data; same packing as req_addr.
REQ-009 SHALL have port grant  output  NCORES  one-hot registered grant; at most one bit set.
REQ-010 SHALL have port ack  output  NCORES  one-hot, one-cycle completion strobe.
REQ-011 SHALL have port rdata  output  32  read data broadcast to all cores, valid while ack is set for a read.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port err  output  1  one-cycle out-of-range strobe, coincident with ack (only with macro, REQ-030).

Function
REQ-014 SHALL implement states IDLE, GRANT, DONE.
REQ-015 IDLE: if any req_valid bit set, SHALL select winner by round-robin starting at pointer rr_ptr, latch its wr/addr/wdata, set grant[winner], go to GRANT; otherwise stay in IDLE.
REQ-016 GRANT: SHALL perform the access at the rising edge; write stores latched wdata at word index addr[AW+1:2]; read loads that word into rdata register; then go to DONE.
REQ-017 DONE: SHALL assert ack[winner] and hold rdata for exactly this cycle, clear grant, set rr_ptr = (winner+1) mod NCORES, go to IDLE.
REQ-018 Latency SHALL be fixed: request seen in IDLE at cycle N -> grant in N+1 -> ack/rdata in N+2; one access per 3 cycles maximum.
REQ-019 Cores SHALL hold req_valid until ack; a request deasserted before being latched SHALL be ignored; once latched, the access SHALL complete even if req_valid drops.
REQ-020 A core's req_valid still high in the cycle after its ack SHALL be treated as a new request.
REQ-021 Simultaneous requests: the first set bit at or after rr_ptr (wrapping at NCORES-1 to 0) SHALL win; no core waits more than NCORES grants.
REQ-022 rdata SHALL retain its last read value outside ack cycles; writes SHALL not change rdata.
REQ-023 Address bits [1:0] SHALL be ignored; bits above AW+1 SHALL be ignored unless REQ-030 applies.
REQ-024 Write-then-read of the same word by any cores SHALL return the written value.

Reset
REQ-025 Reset low SHALL immediately force state IDLE, grant=0, ack=0, err=0, busy=0, rdata=0, rr_ptr=0.
REQ-026 Reset asserted mid-access (GRANT or DONE) SHALL abort without ack; a write not yet clocked in GRANT SHALL not modify memory.
REQ-027 Memory contents SHALL not be cleared by reset.
REQ-028 After reset deasserts, first request SHALL be arbitrated from core 0.

Configuration
REQ-029 Macro SHMEM_BOUNDS_CHECK_EN SHALL select out-of-range checking.
REQ-030 With SHMEM_BOUNDS_CHECK_EN defined: if latched addr[31:AW+2] is nonzero, write SHALL be suppressed, read SHALL return 0, err SHALL pulse with ack; without it, err SHALL be tied 0 and addresses wrap modulo depth.

Verification
REQ-031 Single write: core 2 writes 0xDEADBEEF to 0x0000_0010 -> grant=0b0100 next cycle, ack=0b0100 cycle after; later read by core 0 returns 0xDEADBEEF.
REQ-032 All four cores request in one cycle after reset -> acks in order 0,1,2,3, each 3 cycles apart.
REQ-033 Core 3 requests continuously while core 1 also requests -> grants alternate 1,3,1,3; no starvation.
REQ-034 Reset pulsed during GRANT of a write of 0x12345678 to word 5 -> no ack, word 5 keeps prior value, busy=0 immediately.
REQ-035 Core 1 drops req_valid in the cycle it is raised while core 0 holds -> only core 0 acked.
REQ-036 With macro: write 0xAAAA5555 to 0x0000_0400 (AW=8) -> err=1 with ack, memory unchanged; without macro, word 0 updated.
